key_cmd: RTL
============

KEY_CMD -- requirements
Module: key_cmd

Interface
REQ-001 Parameter STEP_PERIOD, default 30'd833_333, SHALL set the cycles between repeated movement steps (60 Hz at 50 MHz); legal range 2..2^30-1.
REQ-002 Parameter LONG_PRESS, default 30'd10_000_000, SHALL set the jump hold cycles (200 ms) that qualify a high jump; legal range 2..2^30-1.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_in  input  4  debounced key levels, 1 = pressed; bit0 left, bit1 right, bit2 jump, bit3 pause.
REQ-006 step_left  output  1  one-cycle pulse; move Mario one step left.
REQ-007 step_right  output  1  one-cycle pulse; move Mario one step right.
REQ-008 jump_start  output  1  one-cycle pulse; start a normal jump.
REQ-009 jump_high  output  1  one-cycle pulse; extend the current jump to a high jump.
REQ-010 paused  output  1  level; 1 = game paused.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from key_in to any output.
REQ-012 The block SHALL keep key_d[3:0] as key_in delayed one cycle; press edge = key_in & ~key_d; release edge = ~key_in & key_d.
REQ-013 Latency: a pulse caused by a press edge SHALL be high for exactly one cycle, in the cycle after the clock edge that first samples key_in high.
REQ-014 paused SHALL toggle on each press edge of bit3; holding bit3 SHALL NOT cause repeated toggles.
REQ-015 Movement direction: left only = bit0 & ~bit1; right only = bit1 & ~bit0; both held or neither held = no step pulses.
REQ-016 Movement counter: 30-bit step_cnt SHALL count 0..STEP_PERIOD-1 and wrap to 0 while a single direction is held; the wrap cycle is the repeat tick.
REQ-017 A press edge that creates a single-direction condition SHALL produce one immediate step pulse and clear step_cnt to 0. This includes releasing one key while both are held.
REQ-018 While a single direction stays held, one step pulse SHALL fire on each repeat tick, i.e. every STEP_PERIOD cycles after the immediate step.
REQ-019 step_cnt SHALL hold at 0 whenever there is no single direction or paused = 1.
REQ-020 step_left and step_right SHALL never be high in the same cycle.
REQ-021 The jump FSM SHALL have three states: IDLE, CHARGE, WAIT_REL. The reset state is IDLE.
REQ-022 IDLE -> CHARGE on a jump press edge while paused = 0, together with a jump_start pulse and hold_cnt cleared to 0.
REQ-023 In CHARGE, hold_cnt SHALL increment each cycle while bit2 is held.
REQ-024 CHARGE -> IDLE on bit2 release, with no jump_high pulse.
REQ-025 CHARGE -> WAIT_REL when hold_cnt reaches LONG_PRESS-1 with bit2 still held, together with one jump_high pulse.
REQ-026 WAIT_REL -> IDLE when bit2 is released. No pulses are issued in WAIT_REL.
REQ-027 If bit2 is already held when entering IDLE, no jump SHALL start until a new press edge occurs.
REQ-028 hold_cnt SHALL saturate and never wrap.
REQ-029 Pause priority: in the cycle paused becomes 1, the jump FSM SHALL go to IDLE, step_cnt SHALL clear, and all pulse outputs SHALL be 0 from that cycle on.
REQ-030 Unpausing SHALL NOT generate any pulse; movement resumes only after a new press edge or a release that creates a single direction.
REQ-031 A jump press edge and a pause press edge in the same cycle: pause wins, and jump_start SHALL NOT fire.
REQ-032 Simultaneous left and jump press edges SHALL produce step_left and jump_start in the same cycle.

Reset
REQ-033 While rst_n = 0, the block SHALL hold key_d = 0, step_cnt = 0, hold_cnt = 0, FSM = IDLE, all pulse outputs = 0, and paused = 0, independent of clk.
REQ-034 Reset asserted mid-jump or mid-repeat SHALL abort the operation immediately.
REQ-035 After rst_n deasserts, keys already held SHALL count as press edges on the first sampled cycle, because key_d = 0.

Verification (STEP_PERIOD=4, LONG_PRESS=8)
REQ-036 Hold bit0 for 10 cycles -> step_left pulses at cycle offsets 1, 5, 9; step_right stays 0.
REQ-037 Hold bit0, add bit1 at offset 6, drop bit0 at offset 12 -> step_left at offsets 1 and 5; no step during offsets 6-12; step_right at 13 and 17 if bit1 is still held.
REQ-038 Press bit2 for 3 cycles -> jump_start at offset 1; no jump_high; FSM back to IDLE.
REQ-039 Hold bit2 for 20 cycles -> jump_start at offset 1 and jump_high exactly once at offset 9; a re-press after release gives jump_start again.
REQ-040 Hold bit0, pulse bit3 at offset 3 -> paused = 1 from offset 4 and no further steps; pulse bit3 again -> paused = 0 with no step until bit0 is re-pressed.
REQ-041 Hold bit2, assert rst_n = 0 at offset 5 -> all outputs are 0 asynchronously; after release with bit2 still held -> jump_start one cycle after the first sampling edge.

Source files
------------

// File: rtl/key_cmd.sv
// Key-to-command translator: turns debounced key levels into registered
// movement/jump pulses and a pause level, with auto-repeat and long-press jump.
module key_cmd #(
  parameter logic [29:0] STEP_PERIOD = 30'd833_333,
  parameter logic [29:0] LONG_PRESS  = 30'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic       step_left,
  output logic       step_right,
  output logic       jump_start,
  output logic       jump_high,
  output logic       paused
);

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    WAIT_REL
  } jump_state_t;

  jump_state_t state_q, state_d;

  logic [3:0]  key_d;
  logic [29:0] step_cnt_q, step_cnt_d;
  logic [29:0] hold_cnt_q, hold_cnt_d;
  logic        moving_q, moving_d;
  logic        step_l_d, step_r_d, jump_start_d, jump_high_d, paused_d;

  logic press_jump, press_pause, single_dir, dir_changed, block;

  assign press_jump  = key_in[2] & ~key_d[2];
  assign press_pause = key_in[3] & ~key_d[3];
  assign single_dir  = key_in[0] ^ key_in[1];
  assign dir_changed = key_in[1:0] != key_d[1:0];
  // Any pause press (either toggle direction) or an active pause suppresses all pulses.
  assign block       = paused | press_pause;
  assign paused_d    = paused ^ press_pause;

  // Movement: a fresh single-direction condition steps at once, then repeats
  // while it stays unchanged; moving_q keeps a stale hold (after unpause) silent.
  always_comb begin
    step_cnt_d = '0;
    moving_d   = 1'b0;
    step_l_d   = 1'b0;
    step_r_d   = 1'b0;
    if (!block && single_dir) begin
      if (dir_changed) begin
        moving_d = 1'b1;
        step_l_d = key_in[0];
        step_r_d = key_in[1];
      end else if (moving_q) begin
        moving_d = 1'b1;
        if (step_cnt_q == STEP_PERIOD - 30'd1) begin
          step_l_d = key_in[0];
          step_r_d = key_in[1];
        end else begin
          step_cnt_d = step_cnt_q + 30'd1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    jump_start_d = 1'b0;
    jump_high_d  = 1'b0;
    if (block) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_jump) begin
            state_d      = CHARGE;
            hold_cnt_d   = '0;
            jump_start_d = 1'b1;
          end
        end
        CHARGE: begin
          if (!key_in[2]) begin
            state_d = IDLE;
          end else if (hold_cnt_q == LONG_PRESS - 30'd1) begin
            state_d     = WAIT_REL;
            jump_high_d = 1'b1;
          end else if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + 30'd1;
          end
        end
        WAIT_REL: begin
          if (!key_in[2]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_d      <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      moving_q   <= 1'b0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      jump_start <= 1'b0;
      jump_high  <= 1'b0;
      paused     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_d      <= key_in;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      moving_q   <= moving_d;
      step_left  <= step_l_d;
      step_right <= step_r_d;
      jump_start <= jump_start_d;
      jump_high  <= jump_high_d;
      paused     <= paused_d;
    end
  end

endmodule
